// File: rtl/wca_usb_fx3_arbiter_if.sv
// Channel and FX3 port-interface bundle for wca_usb_fx3_arbiter.
// The master modport is the arbiter side; slave is the channel FIFOs plus the FX3 port interface.
interface wca_usb_fx3_arbiter_if #(
    parameter int NBITS_ADDR = 2,
    parameter int NCHAN      = 4
);
    logic [NCHAN-1:0]        chEn;
    logic [NCHAN-1:0]        chDir;
    logic [NCHAN-1:0]        chReq;
    logic [NCHAN-1:0]        chGrant;
    logic [NCHAN-1:0]        chDone;
    logic [NBITS_ADDR+1:0]   pifCtrl;
    logic [6:0]              pifStatus;
    logic                    errTimeout;

    modport master (
        input  chEn, chDir, chReq, pifStatus,
        output chGrant, chDone, pifCtrl, errTimeout
    );

    modport slave (
        output chEn, chDir, chReq, pifStatus,
        input  chGrant, chDone, pifCtrl, errTimeout
    );
endinterface

// File: rtl/wca_usb_fx3_arbiter.sv
// Round-robin arbiter granting FX3 GPIF threads to local burst channels.
// Define WCA_FX3_ARB_PRIO0_EN to give channel 0 absolute priority at selection.
module wca_usb_fx3_arbiter #(
    parameter int NBITS_ADDR    = 2,
    parameter int NCHAN         = 4,
    parameter int SETTLE_CYCLES = 3,
    parameter int TIMEOUT       = 1023
) (
    input  logic                  clk_in,
    input  logic                  reset,
    wca_usb_fx3_arbiter_if.master bus
);
    localparam logic [1:0] PIFCMD_IDLE  = 2'd0;
    localparam logic [1:0] PIFCMD_READ  = 2'd1;
    localparam logic [1:0] PIFCMD_WRITE = 2'd2;

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CHECK,
        ISSUE,
        BUSY,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [NBITS_ADDR-1:0]   addr_q, addr_d;
    logic [NBITS_ADDR-1:0]   ptr_q, ptr_d;
    logic                    dir_q, dir_d;
    logic [SW-1:0]           settle_q, settle_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    err_q, err_d;

    logic [NCHAN-1:0]        active;
    logic [NCHAN-1:0]        chanMask;
    logic                    hiFound, loFound, selFound;
    logic [NBITS_ADDR-1:0]   hiSel, loSel, selChan;
    logic                    flagA, ioBusy;
    logic [1:0]              iocmd;
    logic [NCHAN-1:0]        grant, done;
    logic                    unusedStatus;

    assign flagA        = bus.pifStatus[6];
    assign ioBusy       = bus.pifStatus[4];
    assign unusedStatus = ^{bus.pifStatus[5], bus.pifStatus[3:0]};
    assign active       = bus.chEn & bus.chReq;
    assign chanMask     = NCHAN'(1) << addr_q;

    // Lowest active channel above the pointer wins; otherwise wrap to the lowest active one.
    always_comb begin
        hiFound = 1'b0;
        hiSel   = '0;
        loFound = 1'b0;
        loSel   = '0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (active[i] && (NBITS_ADDR'(i) > ptr_q)) begin
                hiFound = 1'b1;
                hiSel   = NBITS_ADDR'(i);
            end
            if (active[i]) begin
                loFound = 1'b1;
                loSel   = NBITS_ADDR'(i);
            end
        end
        selFound = hiFound | loFound;
        selChan  = hiFound ? hiSel : loSel;
`ifdef WCA_FX3_ARB_PRIO0_EN
        if (active[0]) begin
            selChan = '0;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        ptr_d    = ptr_q;
        dir_d    = dir_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        iocmd    = PIFCMD_IDLE;
        grant    = '0;
        done     = '0;

        unique case (state_q)
            IDLE: begin
                if (selFound) begin
                    addr_d   = selChan;
                    settle_d = '0;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = CHECK;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            CHECK: begin
                if (flagA && |(bus.chReq & chanMask)) begin
                    dir_d   = |(bus.chDir & chanMask);
                    tmo_d   = '0;
                    state_d = ISSUE;
                end else begin
                    ptr_d   = addr_q;
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                iocmd = dir_q ? PIFCMD_WRITE : PIFCMD_READ;
                grant = chanMask;
                if (ioBusy) begin
                    tmo_d   = '0;
                    state_d = BUSY;
                end else if (tmo_q == TW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    ptr_d   = addr_q;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            BUSY: begin
                grant = chanMask;
                if (!ioBusy) begin
                    state_d = DONE;
                end else if (tmo_q == TW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    ptr_d   = addr_q;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            DONE: begin
                done    = chanMask;
                ptr_d   = addr_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pointer starts at the last channel so channel 0 is searched first after reset.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            ptr_q    <= NBITS_ADDR'(NCHAN - 1);
            dir_q    <= 1'b0;
            settle_q <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            ptr_q    <= ptr_d;
            dir_q    <= dir_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
        end
    end

    assign bus.pifCtrl    = {addr_q, iocmd};
    assign bus.chGrant    = grant;
    assign bus.chDone     = done;
    assign bus.errTimeout = err_q;
endmodule
